sd_sector_sched: RTL and testbench

SD_SECTOR_SCHED -- requirements
Module: sd_sector_sched

---
 rtl/sd_sector_sched_if.sv | 33 +++
 rtl/sd_sector_sched.sv | 176 +++++++++++++++++
 tb/tb_sd_sector_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_sched_if.sv
// Bundle of requester, sector-reader and byte-write signals for sd_sector_sched.
// The scheduler takes the slave view; the requesters/reader/memory side takes master.
interface sd_sector_sched_if #(
  parameter int unsigned ADDR_W = 18
) ();
  logic              req0, req1;
  logic [31:0]       base0, base1;
  logic [7:0]        nsec0, nsec1;
  logic [ADDR_W-1:0] dst0, dst1;
  logic              grant0, grant1;
  logic              done0, done1;
  logic              rd_req;
  logic [31:0]       rd_sec;
  logic              rd_done;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              err;

  modport slave (
    input  req0, req1, base0, base1, nsec0, nsec1, dst0, dst1,
    input  rd_done, rd_data, rd_valid,
    output grant0, grant1, done0, done1, rd_req, rd_sec, wr_en, wr_addr, wr_data, err
  );

  modport master (
    output req0, req1, base0, base1, nsec0, nsec1, dst0, dst1,
    output rd_done, rd_data, rd_valid,
    input  grant0, grant1, done0, done1, rd_req, rd_sec, wr_en, wr_addr, wr_data, err
  );
endinterface

// File: rtl/sd_sector_sched.sv
// sd_sector_sched: round-robin arbiter between two requesters for one SD sector reader.
// A granted transfer walks nsec sectors from base, copying each reader byte to
// dst + sector*512 + byte. Define SCHED_TIMEOUT_EN to enable the per-sector WAIT
// timeout (ERR state, sticky err); without it err is tied low and WAIT never expires.
module sd_sector_sched #(
  parameter int unsigned ADDR_W  = 18,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input logic              SD_clk,
  input logic              init,
  sd_sector_sched_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StFinish, StErr} state_e;

  state_e            state_q;
  logic              last_q;      // requester served last; loses the next tie
  logic              owner_q;
  logic [31:0]       base_q;
  logic [7:0]        nsec_q;      // effective count, a request of 0 is stored as 1
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        sec_idx_q;
  logic [9:0]        byte_cnt_q;  // saturates at 512
  logic              rd_done_q;
  logic              grant0_q, grant1_q, done0_q, done1_q, rd_req_q, wr_en_q;
  logic [31:0]       rd_sec_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic              win_sel;
  logic [31:0]       win_base;
  logic [7:0]        win_nsec;
  logic [ADDR_W-1:0] win_dst;
  logic [8:0]        sec_nxt;
  logic [31:0]       wr_off;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              done_rise;

`ifdef SCHED_TIMEOUT_EN
  logic [23:0]       tmo_q;
  logic              err_q;
  assign bus.err = err_q;
`else
  logic              unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.err = 1'b0;
`endif

  // Arbitration pick, next sector index, byte address and rd_done edge detect
  always_comb begin
    win_sel  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    win_base = win_sel ? bus.base1 : bus.base0;
    win_nsec = win_sel ? bus.nsec1 : bus.nsec0;
    if (win_nsec == 8'd0) win_nsec = 8'd1;
    win_dst     = win_sel ? bus.dst1 : bus.dst0;
    sec_nxt     = {1'b0, sec_idx_q} + 9'd1;
    wr_off      = {15'd0, sec_idx_q, 9'd0} + {22'd0, byte_cnt_q};
    wr_addr_nxt = dst_q + wr_off[ADDR_W-1:0];
    done_rise   = bus.rd_done & ~rd_done_q;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge SD_clk or negedge init) begin
    if (!init) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      base_q     <= '0;
      nsec_q     <= 8'd1;
      dst_q      <= '0;
      sec_idx_q  <= '0;
      byte_cnt_q <= '0;
      rd_done_q  <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_sec_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef SCHED_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      rd_done_q <= bus.rd_done;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            owner_q    <= win_sel;
            base_q     <= win_base;
            nsec_q     <= win_nsec;
            dst_q      <= win_dst;
            grant0_q   <= ~win_sel;
            grant1_q   <= win_sel;
            sec_idx_q  <= '0;
            byte_cnt_q <= '0;
            rd_req_q   <= 1'b1;
            rd_sec_q   <= win_base;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
`ifdef SCHED_TIMEOUT_EN
          tmo_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          // Bytes past 512 in one sector are dropped
          if (bus.rd_valid && byte_cnt_q != 10'd512) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= bus.rd_data;
            wr_addr_q  <= wr_addr_nxt;
            byte_cnt_q <= byte_cnt_q + 10'd1;
          end
`ifdef SCHED_TIMEOUT_EN
          tmo_q <= bus.rd_valid ? 24'd0 : tmo_q + 24'd1;
          if (done_rise) begin
            state_q <= StNext;
          end else if (!bus.rd_valid && tmo_q == TIMEOUT - 24'd1) begin
            err_q    <= 1'b1;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            state_q  <= StErr;
          end
`else
          if (done_rise) state_q <= StNext;
`endif
        end
        StNext: begin
          sec_idx_q <= sec_nxt[7:0];
          if (sec_nxt < {1'b0, nsec_q}) begin
            byte_cnt_q <= '0;
            rd_req_q   <= 1'b1;
            rd_sec_q   <= base_q + {23'd0, sec_nxt};
            state_q    <= StIssue;
          end else begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          grant0_q <= 1'b0;
          grant1_q <= 1'b0;
          last_q   <= owner_q;
          state_q  <= StIdle;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.grant0  = grant0_q;
  assign bus.grant1  = grant1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_sec  = rd_sec_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_sd_sector_sched.sv
// Bench for sd_sector_sched: a transaction-level model predicts the sector sequence,
// byte writes and done owners; a reader model answers rd_req with a byte stream.
`timescale 1ns/1ps
module tb_sd_sector_sched;
  localparam int unsigned AW = 18;
`ifdef SCHED_TIMEOUT_EN
  localparam logic [23:0] TMO = 24'd100;
`else
  localparam logic [23:0] TMO = 24'd2000000;
`endif

  logic SD_clk = 1'b0;
  logic init   = 1'b0;
  always #5 SD_clk = ~SD_clk;

  sd_sector_sched_if #(.ADDR_W(AW)) bus ();
  sd_sector_sched #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (.SD_clk(SD_clk), .init(init), .bus(bus));

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic own; logic [31:0] sec; } sec_t;

  wr_t         exp_wr[$];
  sec_t        exp_sec[$];
  int          exp_done[$];
  int          done_order[$];
  logic [31:0] sec_log[$];
  int checks = 0, fails = 0;
  int wr_count = 0, rd_req_count = 0, done0_count = 0, done1_count = 0;
  logic [AW-1:0] last_wr_addr = '0;
  int rd_nbytes = 16;
  bit hold_mode = 1'b0, silent = 1'b0;

  function automatic logic [7:0] pat(input logic [31:0] sec, input int b);
    return 8'(sec * 32'd7 + 32'(b) * 32'd3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge SD_clk);
    #1;
  endtask

  // Model: what a transfer must produce, straight from its parameters
  task automatic expect_xfer(input int own, input logic [31:0] base, input int nsec,
                             input logic [AW-1:0] dst, input int nbytes);
    int eff, nb;
    sec_t s_e;
    wr_t w_e;
    logic [31:0] a;
    eff = (nsec == 0) ? 1 : nsec;
    nb  = (nbytes > 512) ? 512 : nbytes;
    for (int s = 0; s < eff; s++) begin
      s_e.own = 1'(own);
      s_e.sec = base + 32'(s);
      exp_sec.push_back(s_e);
      for (int b = 0; b < nb; b++) begin
        a = 32'(dst) + 32'(s * 512 + b);
        w_e.addr = a[AW-1:0];
        w_e.data = pat(base + 32'(s), b);
        exp_wr.push_back(w_e);
      end
    end
    exp_done.push_back(own);
  endtask

  task automatic wait_done(input int idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((idx == 0 && bus.done0) || (idx == 1 && bus.done1)) begin
        if (idx == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
        return;
      end
    end
    chk($sformatf("done%0d_wait_expired", idx), 1, 0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_wr.size() == 0 && exp_sec.size() == 0 && exp_done.size() == 0 &&
          !bus.grant0 && !bus.grant1) break;
      tick();
    end
    chk("drain_pending", exp_wr.size() + exp_sec.size() + exp_done.size(), 0);
    chk("drain_grant", {bus.grant0, bus.grant1}, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant0"}, bus.grant0, 0);
    chk({tag, "_grant1"}, bus.grant1, 0);
    chk({tag, "_done0"}, bus.done0, 0);
    chk({tag, "_done1"}, bus.done1, 0);
    chk({tag, "_rd_req"}, bus.rd_req, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_rd_sec"}, bus.rd_sec, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
  endtask

  // Compare process: every output event is matched against the model queues
  initial begin : compare
    sec_t es;
    wr_t  ew;
    int   o;
    logic rd_req_prev;
    rd_req_prev = 1'b0;
    forever begin
      @(negedge SD_clk);
      if (init) begin
        chk("grant_onehot", bus.grant0 & bus.grant1, 0);
        if (bus.rd_req) begin
          rd_req_count++;
          sec_log.push_back(bus.rd_sec);
          chk("rd_req_single_cycle", rd_req_prev, 0);
          if (exp_sec.size() == 0) chk("rd_req_unexpected", 1, 0);
          else begin
            es = exp_sec.pop_front();
            chk("rd_sec", bus.rd_sec, es.sec);
            chk("rd_req_owner_grant", es.own ? bus.grant1 : bus.grant0, 1);
          end
        end
        if (bus.wr_en) begin
          wr_count++;
          last_wr_addr = bus.wr_addr;
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            ew = exp_wr.pop_front();
            chk("wr_addr", bus.wr_addr, ew.addr);
            chk("wr_data", bus.wr_data, ew.data);
          end
        end
        if (bus.done0 || bus.done1) begin
          chk("done_both", bus.done0 & bus.done1, 0);
          o = bus.done1 ? 1 : 0;
          done_order.push_back(o);
          if (o == 1) done1_count++;
          else done0_count++;
          if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_owner", o, exp_done.pop_front());
        end
`ifndef SCHED_TIMEOUT_EN
        chk("err_tied_low", bus.err, 0);
`endif
        rd_req_prev = bus.rd_req;
      end else begin
        rd_req_prev = 1'b0;
      end
    end
  end

  // Sector reader: gap, rd_nbytes bytes, short tail, then rd_done rises
  initial begin : reader
    int phase, cnt;
    logic [31:0] sec;
    phase = 0;
    cnt = 0;
    sec = '0;
    bus.rd_done  = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge SD_clk);
      if (!init) begin
        phase = 0;
        cnt = 0;
        bus.rd_valid = 1'b0;
        bus.rd_done  = 1'b0;
      end else begin
        case (phase)
          0: begin
            bus.rd_valid = 1'b0;
            if (hold_mode) bus.rd_done = 1'b1;
            if (bus.rd_req) begin
              sec = bus.rd_sec;
              cnt = 0;
              if (!hold_mode) bus.rd_done = 1'b0;
              phase = silent ? 4 : 1;
            end
          end
          1: phase = 2;
          2: begin
            if (cnt < rd_nbytes) begin
              bus.rd_valid = 1'b1;
              bus.rd_data  = pat(sec, cnt);
              cnt++;
            end else begin
              bus.rd_valid = 1'b0;
              cnt = 0;
              phase = 3;
            end
          end
          3: begin
            cnt++;
            if (hold_mode) begin
              if (cnt == 40) bus.rd_done = 1'b0;
              else if (cnt == 41) begin
                bus.rd_done = 1'b1;
                phase = 0;
              end
            end else if (cnt == 3) begin
              bus.rd_done = 1'b1;
              phase = 0;
            end
          end
          default: if (!silent) phase = 0;
        endcase
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wc, rq, d0, d1, n;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.base0 = '0; bus.base1 = '0;
    bus.nsec0 = '0; bus.nsec1 = '0;
    bus.dst0 = '0;  bus.dst1 = '0;
    repeat (3) tick();
    check_reset("por");
    init = 1'b1;
    tick();

    // Simultaneous pair after reset: req0 first; req0 re-raised while req1 waits -> req1
    rd_nbytes = 16;
    bus.base0 = 32'd10; bus.nsec0 = 8'd0; bus.dst0 = 18'h00100;
    bus.base1 = 32'd20; bus.nsec1 = 8'd1; bus.dst1 = 18'h00200;
    expect_xfer(0, 32'd10, 0, 18'h00100, 16);
    expect_xfer(1, 32'd20, 1, 18'h00200, 16);
    expect_xfer(0, 32'd10, 0, 18'h00100, 16);
    done_order.delete();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(0, 300);
    tick();
    bus.req0 = 1'b1;
    wait_done(1, 300);
    wait_done(0, 300);
    wait_drain(20);
    chk("pair_order0", done_order[0], 0);
    chk("pair_order1", done_order[1], 1);
    chk("pair_order2", done_order[2], 0);

    // Two full sectors from 100 to address 0
    rd_nbytes = 512;
    bus.base0 = 32'd100; bus.nsec0 = 8'd2; bus.dst0 = '0;
    wc = wr_count; d0 = done0_count; sec_log.delete();
    expect_xfer(0, 32'd100, 2, '0, 512);
    bus.req0 = 1'b1;
    wait_done(0, 3000);
    wait_drain(20);
    chk("two_sec_writes", wr_count - wc, 1024);
    chk("two_sec_last_addr", last_wr_addr, 1023);
    chk("two_sec_sec0", sec_log[0], 100);
    chk("two_sec_sec1", sec_log[1], 101);
    chk("two_sec_done0", done0_count - d0, 1);

    // 520 bytes in one sector; address wraps at 2^18
    rd_nbytes = 520;
    bus.base0 = 32'd7; bus.nsec0 = 8'd1; bus.dst0 = 18'd262044;
    wc = wr_count;
    expect_xfer(0, 32'd7, 1, 18'd262044, 520);
    bus.req0 = 1'b1;
    wait_done(0, 1000);
    wait_drain(20);
    chk("overrun_writes", wr_count - wc, 512);
    chk("overrun_last_addr", last_wr_addr, 411);

    // req1 dropped right after its first sector is issued
    rd_nbytes = 8;
    bus.base1 = 32'd500; bus.nsec1 = 8'd2; bus.dst1 = 18'h01000;
    wc = wr_count; rq = rd_req_count; d1 = done1_count;
    expect_xfer(1, 32'd500, 2, 18'h01000, 8);
    bus.req1 = 1'b1;
    for (int i = 0; i < 50 && rd_req_count == rq; i++) tick();
    chk("drop_issue_seen", rd_req_count - rq, 1);
    bus.req1 = 1'b0;
    wait_done(1, 300);
    wait_drain(20);
    chk("drop_writes", wr_count - wc, 16);
    chk("drop_done1", done1_count - d1, 1);

    // rd_done already high entering WAIT: only a fresh rising edge advances
    rd_nbytes = 32;
    hold_mode = 1'b1;
    repeat (3) tick();
    bus.base0 = 32'd40; bus.nsec0 = 8'd2; bus.dst0 = 18'h02000;
    wc = wr_count; rq = rd_req_count; d0 = done0_count;
    expect_xfer(0, 32'd40, 2, 18'h02000, 32);
    bus.req0 = 1'b1;
    for (int i = 0; i < 200 && wr_count - wc < 32; i++) tick();
    repeat (20) tick();
    chk("hold_no_next", rd_req_count - rq, 1);
    chk("hold_no_done", done0_count - d0, 0);
    wait_done(0, 500);
    hold_mode = 1'b0;
    wait_drain(20);
    chk("hold_two_issues", rd_req_count - rq, 2);

    // init pulsed low during the 300th byte
    rd_nbytes = 512;
    bus.base0 = 32'd300; bus.nsec0 = 8'd2; bus.dst0 = 18'h03000;
    wc = wr_count; d0 = done0_count; d1 = done1_count;
    expect_xfer(0, 32'd300, 2, 18'h03000, 512);
    bus.req0 = 1'b1;
    for (int i = 0; i < 2000 && wr_count - wc < 299; i++) tick();
    chk("rst_at_300th", wr_count - wc, 299);
    init = 1'b0;
    #1;
    check_reset("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_done", bus.done0 | bus.done1, 0);
    end
    exp_wr.delete(); exp_sec.delete(); exp_done.delete();
    bus.req0 = 1'b0;
    init = 1'b1;
    repeat (3) tick();
    chk("midrst_writes", wr_count - wc, 299);
    chk("midrst_done_cnt", (done0_count - d0) + (done1_count - d1), 0);

    // Pair after reset: last served is back to 1, so req0 wins
    rd_nbytes = 4;
    bus.base0 = 32'd1; bus.nsec0 = 8'd1; bus.dst0 = '0;
    bus.base1 = 32'd2; bus.nsec1 = 8'd1; bus.dst1 = 18'h00010;
    expect_xfer(0, 32'd1, 1, '0, 4);
    expect_xfer(1, 32'd2, 1, 18'h00010, 4);
    done_order.delete();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(0, 200);
    wait_done(1, 200);
    wait_drain(20);
    chk("rst_pair_first", done_order[0], 0);
    chk("rst_pair_second", done_order[1], 1);

`ifdef SCHED_TIMEOUT_EN
    // Silent reader: err after 100 WAIT cycles, grant dropped, no done
    silent = 1'b1;
    bus.base0 = 32'd9; bus.nsec0 = 8'd1; bus.dst0 = '0;
    begin
      sec_t s9;
      s9.own = 1'b0;
      s9.sec = 32'd9;
      exp_sec.push_back(s9);
    end
    rq = rd_req_count; d0 = done0_count;
    bus.req0 = 1'b1;
    for (int i = 0; i < 50 && rd_req_count == rq; i++) tick();
    n = 0;
    while (!bus.err && n < 150) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 101);
    chk("tmo_err", bus.err, 1);
    chk("tmo_grant0", bus.grant0, 0);
    bus.req0 = 1'b0;
    silent = 1'b0;
    repeat (5) tick();
    chk("tmo_err_sticky", bus.err, 1);
    chk("tmo_no_regrant", bus.grant0, 0);
    chk("tmo_no_done", done0_count - d0, 0);
`endif

    chk("final_queues", exp_wr.size() + exp_sec.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
